// File: rtl/fetch_pc_unit.sv
// IF stage of the rv32i_seg pipeline: owns the PC, runs the IMEM
// req/ready handshake and loads the IF/ID pipeline register.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic [XLEN-1:0] PCOutput,
    input  logic [XLEN-1:0] AdderOutput,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemReady,
    input  logic [XLEN-1:0] IMemData,
    output logic            IFID_Valid,
    output logic [XLEN-1:0] IFID_PC,
    output logic [XLEN-1:0] IFID_PCPlus4,
    output logic [XLEN-1:0] IFID_Instr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic            req_q;
    logic [XLEN-1:0] buf_q;
    logic            valid_q;
    logic [XLEN-1:0] ifid_pc_q;
    logic [XLEN-1:0] ifid_pc4_q;
    logic [XLEN-1:0] ifid_instr_q;

    logic [XLEN-1:0] redirect_pc;
    logic            deliver_req;
    logic            deliver_hold;

    // Redirect targets are always word aligned.
    assign redirect_pc  = RedirectPC & ~XLEN'(3);

    // An instruction reaches IF/ID only when neither redirect nor stall is active.
    assign deliver_req  = (state_q == REQ)  && IMemReady && !Redirect && !Stall;
    assign deliver_hold = (state_q == HOLD) && !Redirect && !Stall;

    // Fetch FSM: PC, request address/valid and the stall hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (!Stall) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= Redirect ? redirect_pc : pc_q;
                    end
                end
                REQ: begin
                    if (Redirect) begin
                        pc_q <= redirect_pc;
                        if (IMemReady) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            // Request must stay up at the old address until accepted.
                            state_q <= SQUASH;
                        end
                    end else if (IMemReady) begin
                        if (Stall) begin
                            buf_q   <= IMemData;
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            pc_q   <= AdderOutput;
                            addr_q <= AdderOutput;
                        end
                    end
                end
                HOLD: begin
                    if (Redirect) begin
                        pc_q    <= redirect_pc;
                        buf_q   <= '0;
                        state_q <= IDLE;
                    end else if (!Stall) begin
                        pc_q    <= AdderOutput;
                        addr_q  <= AdderOutput;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                SQUASH: begin
                    if (Redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (IMemReady) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: redirect bubbles, stall holds, else load or bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
        end else if (deliver_req) begin
            valid_q      <= 1'b1;
            ifid_pc_q    <= addr_q;
            ifid_pc4_q   <= AdderOutput;
            ifid_instr_q <= IMemData;
        end else if (deliver_hold) begin
            valid_q      <= 1'b1;
            ifid_pc_q    <= pc_q;
            ifid_pc4_q   <= AdderOutput;
            ifid_instr_q <= buf_q;
        end else if (Redirect || !Stall) begin
            valid_q <= 1'b0;
        end
    end

    assign PCOutput     = pc_q;
    assign IMemReq      = req_q;
    assign IMemAddr     = addr_q;
    assign IFID_Valid   = valid_q;
    assign IFID_PC      = ifid_pc_q;
    assign IFID_PCPlus4 = ifid_pc4_q;
    assign IFID_Instr   = ifid_instr_q;

endmodule
